mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter sharing one main-memory port between cache controllers.
// Optional macro ARB_WB_PRIORITY_EN lets a write-back beat a refill read on contention.
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              rw0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner,
  output logic              busy,
  output logic [7:0]        grant_cnt0,
  output logic [7:0]        grant_cnt1,
  output logic [1:0]        state_dbg
);

  // Handshake: a port holds req high until it sees its one-cycle ack; mem_req stays
  // high with stable fields until the memory returns a single-cycle mem_ready.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   rr_ptr;
  logic   win;

  assign state_dbg = state;

  always_comb begin
    win = rr_ptr;
    if (req0 && !req1) begin
      win = 1'b0;
    end else if (req1 && !req0) begin
      win = 1'b1;
    end
`ifdef ARB_WB_PRIORITY_EN
    else if (req0 && req1 && (rw0 != rw1)) begin
      win = rw1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      owner      <= 1'b0;
      busy       <= 1'b0;
      mem_req    <= 1'b0;
      mem_rw     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata      <= '0;
      grant_cnt0 <= 8'd0;
      grant_cnt1 <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner     <= win;
            mem_rw    <= win ? rw1 : rw0;
            mem_addr  <= win ? addr1 : addr0;
            mem_wdata <= win ? wdata1 : wdata0;
            mem_req   <= 1'b1;
            busy      <= 1'b1;
            state     <= MEM;
          end
        end
        MEM: begin
          if (mem_ready) begin
            // Write-backs leave rdata untouched so it keeps the last read value.
            if (!mem_rw) rdata <= mem_rdata;
            mem_req <= 1'b0;
            ack0    <= ~owner;
            ack1    <= owner;
            state   <= RESP;
          end
        end
        RESP: begin
          ack0   <= 1'b0;
          ack1   <= 1'b0;
          busy   <= 1'b0;
          rr_ptr <= ~owner;
          if (!owner && grant_cnt0 != 8'hFF) grant_cnt0 <= grant_cnt0 + 8'd1;
          if (owner && grant_cnt1 != 8'hFF) grant_cnt1 <= grant_cnt1 + 8'd1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single transactions plus hand-written
// sequences for stray strobes, owner changes, reset mid-access, priority and saturation.
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, rw0, req1, rw1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata;
  logic          mem_req, mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          owner, busy;
  logic [7:0]    grant_cnt0, grant_cnt1;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .owner(owner), .busy(busy), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
    .state_dbg(state_dbg)
  );

  typedef struct {
    logic          req0;
    logic          rw0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          req1;
    logic          rw1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    int            wait_cyc;
    logic [DW-1:0] mem_data;
    logic          exp_owner;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t          vecs[8];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            cnt0_m = 0;
  int            cnt1_m = 0;
  int            ack1_seen = 0;
  logic [DW:0]   exp_q[$];

  function automatic vec_t mk(input logic r0, input logic w0, input logic [AW-1:0] a0,
                              input logic [DW-1:0] d0, input logic r1, input logic w1,
                              input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                              input int wc, input logic [DW-1:0] md, input logic eo,
                              input logic [DW-1:0] er);
    vec_t v;
    v.req0 = r0; v.rw0 = w0; v.addr0 = a0; v.wdata0 = d0;
    v.req1 = r1; v.rw1 = w1; v.addr1 = a1; v.wdata1 = d1;
    v.wait_cyc = wc; v.mem_data = md; v.exp_owner = eo; v.exp_rdata = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    req0 = 0; rw0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; rw1 = 0; addr1 = '0; wdata1 = '0;
    mem_ready = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    clear_inputs();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    cnt0_m = 0; cnt1_m = 0;
  endtask

  // One complete transaction: arbitration, memory wait, ack, return to IDLE.
  task automatic run_txn(input vec_t v, input string tag);
    logic [DW-1:0] e_addr, e_wdata;
    logic          e_rw;
    logic [DW:0]   sb;
    e_rw    = v.exp_owner ? v.rw1 : v.rw0;
    e_addr  = v.exp_owner ? DW'(v.addr1) : DW'(v.addr0);
    e_wdata = v.exp_owner ? v.wdata1 : v.wdata0;
    req0 = v.req0; rw0 = v.rw0; addr0 = v.addr0; wdata0 = v.wdata0;
    req1 = v.req1; rw1 = v.rw1; addr1 = v.addr1; wdata1 = v.wdata1;
    exp_q.push_back({v.exp_owner, v.exp_rdata});
    @(posedge clk); #1;
    chk({tag, "_mem_req"}, mem_req, 1);
    chk({tag, "_owner"}, owner, v.exp_owner);
    chk({tag, "_mem_rw"}, mem_rw, e_rw);
    chk({tag, "_mem_addr"}, mem_addr, e_addr);
    chk({tag, "_mem_wdata"}, mem_wdata, e_wdata);
    chk({tag, "_busy"}, busy, 1);
    for (int i = 0; i < v.wait_cyc; i++) begin
      @(posedge clk); #1;
      chk({tag, "_wait_mem_req"}, mem_req, 1);
      chk({tag, "_wait_no_ack"}, {ack0, ack1}, 2'b00);
    end
    mem_ready = 1'b1; mem_rdata = v.mem_data;
    @(posedge clk); #1;
    mem_ready = 1'b0; mem_rdata = '0;
    chk({tag, "_ack0"}, ack0, !v.exp_owner);
    chk({tag, "_ack1"}, ack1, v.exp_owner);
    chk({tag, "_rdata"}, rdata, v.exp_rdata);
    chk({tag, "_mem_req_drop"}, mem_req, 0);
    if (ack1) ack1_seen++;
    if (ack0 || ack1) begin
      if (exp_q.size() > 0) begin
        sb = exp_q.pop_front();
        chk({tag, "_sb"}, {ack1, rdata}, sb);
      end
    end
    req0 = 0; req1 = 0;
    @(posedge clk); #1;
    if (v.exp_owner) begin
      if (cnt1_m < 255) cnt1_m++;
    end else begin
      if (cnt0_m < 255) cnt0_m++;
    end
    chk({tag, "_ack_clear"}, {ack0, ack1}, 2'b00);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_cnt0"}, grant_cnt0, cnt0_m);
    chk({tag, "_cnt1"}, grant_cnt1, cnt1_m);
  endtask

  initial begin
    vec_t pv;
    clear_inputs();
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_acks", {ack0, ack1}, 2'b00);
    chk("rst_owner", owner, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnts", {grant_cnt0, grant_cnt1}, 16'h0000);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_fields", {mem_rw, mem_addr, mem_wdata}, 0);
    chk("rst_state", state_dbg, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    vecs[0] = mk(1, 0, 16'h1234, 32'h0,        0, 0, 16'h0,    32'h0,        3, 32'hDEADBEEF, 0, 32'hDEADBEEF);
    vecs[1] = mk(1, 0, 16'h0010, 32'h0,        1, 0, 16'h0020, 32'h0,        0, 32'h11111111, 1, 32'h11111111);
    vecs[2] = mk(1, 0, 16'h0010, 32'h0,        1, 0, 16'h0020, 32'h0,        0, 32'h22222222, 0, 32'h22222222);
    vecs[3] = mk(1, 0, 16'h0010, 32'h0,        1, 0, 16'h0020, 32'h0,        1, 32'h33333333, 1, 32'h33333333);
    vecs[4] = mk(0, 0, 16'h0,    32'h0,        1, 1, 16'hBEEF, 32'hCAFEF00D, 0, 32'h44444444, 1, 32'h33333333);
    vecs[5] = mk(1, 1, 16'h0F0F, 32'hA5A5A5A5, 0, 0, 16'h0,    32'h0,        1, 32'hFFFFFFFF, 0, 32'h33333333);
    vecs[6] = mk(1, 1, 16'h0055, 32'h9999AAAA, 1, 1, 16'h00AA, 32'h12345678, 0, 32'h0,        1, 32'h33333333);
    vecs[7] = mk(1, 0, 16'h0066, 32'h0,        1, 0, 16'h0077, 32'h0,        2, 32'h0BADF00D, 0, 32'h0BADF00D);
    for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Stray memory strobe while idle.
    mem_ready = 1'b1; mem_rdata = 32'h55555555;
    @(posedge clk); #1;
    mem_ready = 1'b0; mem_rdata = '0;
    chk("stray_busy", busy, 0);
    chk("stray_mem_req", mem_req, 0);
    chk("stray_acks", {ack0, ack1}, 2'b00);
    chk("stray_rdata", rdata, 32'h0BADF00D);
    @(posedge clk); #1;
    chk("stray_acks_late", {ack0, ack1}, 2'b00);

    // Owner drops req and changes fields mid-access; the other port raises req meanwhile.
    req0 = 1; rw0 = 0; addr0 = 16'h0777;
    @(posedge clk); #1;
    chk("mid_owner", owner, 0);
    req0 = 0; rw0 = 1; addr0 = 16'h0999;
    req1 = 1; rw1 = 0; addr1 = 16'h0321;
    @(posedge clk); #1;
    chk("mid_addr_stable", mem_addr, 16'h0777);
    chk("mid_rw_stable", mem_rw, 0);
    chk("mid_owner_stable", owner, 0);
    mem_ready = 1'b1; mem_rdata = 32'h600DCAFE;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    chk("mid_ack0", ack0, 1);
    chk("mid_no_ack1", ack1, 0);
    chk("mid_rdata", rdata, 32'h600DCAFE);
    @(posedge clk); #1;
    cnt0_m++;
    chk("mid_idle", busy, 0);
    chk("mid_cnt0", grant_cnt0, cnt0_m);
    @(posedge clk); #1;
    chk("mid_next_owner", owner, 1);
    chk("mid_next_addr", mem_addr, 16'h0321);
    req1 = 0;
    mem_ready = 1'b1; mem_rdata = 32'h0000ABCD;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    chk("mid_ack1", {ack0, ack1}, 2'b01);
    chk("mid_rdata2", rdata, 32'h0000ABCD);
    @(posedge clk); #1;
    cnt1_m++;
    chk("mid_cnt1", grant_cnt1, cnt1_m);

    // Reset two cycles into a port 1 access, between clock edges.
    req1 = 1; rw1 = 0; addr1 = 16'h4444;
    @(posedge clk); #1;
    chk("rmid_owner", owner, 1);
    @(posedge clk); @(posedge clk); #3;
    chk("rmid_mem_req_before", mem_req, 1);
    reset = 1'b0;
    #1;
    chk("rmid_mem_req_drop", mem_req, 0);
    chk("rmid_busy", busy, 0);
    chk("rmid_owner_rst", owner, 0);
    chk("rmid_cnts", {grant_cnt0, grant_cnt1}, 16'h0000);
    clear_inputs();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    cnt0_m = 0; cnt1_m = 0;
    @(posedge clk); #1;
    chk("rmid_no_ack", {ack0, ack1}, 2'b00);
    run_txn(mk(1, 0, 16'h0A0A, 32'h0, 1, 0, 16'h0B0B, 32'h0, 0, 32'h13572468, 0, 32'h13572468), "rmid_first");

    // Simultaneous read on port 0 and write-back on port 1 right after reset.
    do_reset();
`ifdef ARB_WB_PRIORITY_EN
    pv = mk(1, 0, 16'h0100, 32'h0, 1, 1, 16'h0200, 32'h77777777, 0, 32'h88888888, 1, 32'h0);
`else
    pv = mk(1, 0, 16'h0100, 32'h0, 1, 1, 16'h0200, 32'h77777777, 0, 32'h88888888, 0, 32'h88888888);
`endif
    run_txn(pv, "prio");

    // Port 1 write-backs back to back until the grant counter saturates.
    do_reset();
    ack1_seen = 0;
    for (int i = 0; i < 260; i++) begin
      run_txn(mk(0, 0, 16'h0, 32'h0, 1, 1, AW'(i), DW'(i), 0, 32'h0, 1, 32'h0), "sat");
    end
    chk("sat_cnt1_final", grant_cnt1, 8'd255);
    chk("sat_ack1_pulses", ack1_seen, 260);
    chk("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
